spi_slave_regs: RTL and testbench
=================================

Name: spi_slave_regs

Overview:
- SPI target (slave-side responder) for the spi_module master: a small byte-addressed register file reachable over SCK/SS/MOSI/MISO.
- Oversamples the SPI pins on the system clock, decodes a command byte, then streams auto-incrementing register writes or reads.
- Sits on the far end of the SPI link in the test environment and in SoC builds that need a simple peripheral target.

Parameters:
- CPOL, 0, SCK idle level.
- CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge.
- ADDR_W, 3, register address width; register count NUM_REGS = 2**ADDR_W.

Ports:
- i_sys_clk  input  1  system clock; must be at least 4x the SCK frequency.
- i_sys_rst  input  1  synchronous, active-high reset.
- i_SCK  input  1  SPI clock from master (asynchronous).
- i_SS  input  1  slave select, active-low (asynchronous).
- i_MOSI  input  1  master-out data (asynchronous).
- o_MISO  output  1  slave-out data.
- o_MISO_oe  output  1  MISO output enable; 1 only while SS is synchronised low.
- o_wr_pulse  output  1  one-cycle pulse per completed register write.
- o_wr_addr  output  ADDR_W  address of the last completed write.
- o_frame_done  output  1  one-cycle pulse on synchronised SS rising edge.
- o_regs  output  8*NUM_REGS  flattened register file; reg[k] = o_regs[8k+7:8k].

Behaviour:
- Synchronisation
  - SCK, SS and MOSI each pass through 2-flop synchronisers.
  - Edges are detected from the synchronised SCK (current vs previous sample).
  - Sample edge = rising when CPOL==CPHA, otherwise falling. Shift edge = the opposite edge.
  - An edge is acted on 3 system cycles after the pin transition.
- Frame format
  - Bit order is MSB first; bytes are 8 bits.
  - Byte0 is the command: bit7 = 1 write, 0 read; bits[ADDR_W-1:0] = start address; remaining bits ignored.
  - Bytes 1..N are data. The address auto-increments after each data byte and wraps from NUM_REGS-1 to 0.
- FSM states: IDLE, CMD, WDATA, RDATA.
  - IDLE -> CMD on synchronised SS falling. On entry: bit counter = 0, rx shifter cleared.
  - CMD -> WDATA or RDATA on the 8th sample edge. On this edge: latch the address; for a read, load the tx shifter with reg[addr].
  - In WDATA, each 8th sample edge writes the rx byte to reg[addr] in the same cycle and asserts o_wr_pulse for 1 cycle with o_wr_addr = addr. The address then increments.
  - In RDATA, each 8th sample edge reloads the tx shifter from reg[addr+1] and increments the address. The read value is the register contents at the reload cycle.
  - Any state -> IDLE on synchronised SS rising, with o_frame_done pulsed for 1 cycle.
- MISO
  - o_MISO = tx shifter bit7. The shifter shifts left on shift edges.
  - With CPHA=1, the first shift edge of each byte does not shift; it only exposes the MSB.
  - The tx shifter is 0x00 during CMD, so MISO is 0 for the whole command byte.
  - o_MISO_oe = ~SS_sync.
- Boundary conditions
  - SS rising mid-byte: the partial byte is discarded, no register write, no pulse.
  - SS rising exactly on an 8th sample edge: the write completes first, then the frame ends.
  - SCK edges while SS is high are ignored.
  - A read of any length is non-destructive.
- Reset values (synchronous reset, any time including mid-frame)
  - FSM = IDLE; all regs = 0x00; shifters = 0; counters = 0; synchroniser flops = idle values (SS = 1, SCK = CPOL).
  - o_MISO = 0, o_MISO_oe = 0, o_wr_pulse = 0, o_wr_addr = 0, o_frame_done = 0.

Decomposition:
- Shared package spi_pkg holds:
  - the state enum;
  - the command field constants CMD_WR_BIT = 7 and CMD_ADDR_LSB = 0;
  - the function deriving the sample-edge polarity from CPOL/CPHA.
- Sub-module spi_slave_sync handles the 2-flop synchronisers plus SCK edge and SS edge detection. Its outputs are sample_edge, shift_edge, ss_fall, ss_rise, mosi_s and ss_s.

Test Plan:
- Mode 0, write frame 0x82 0x11 0x22 -> reg2 = 0x11, reg3 = 0x22; two o_wr_pulse with o_wr_addr 2 then 3; one o_frame_done.
- Mode 0, wrap: write 0x87 0xAA 0xBB, then read 0x07 plus 2 dummy bytes -> MISO bytes 0x00, 0xAA, 0xBB; reg7 = 0xAA, reg0 = 0xBB.
- Mode 3, read 0x02 plus 1 dummy after reg2 = 0x5C -> MISO returns 0x5C; o_MISO_oe low before SS falls and after SS rises.
- Abort: write 0x81, 5 bits of 0xFF, then SS high -> reg1 unchanged (0x00), no o_wr_pulse, o_frame_done = 1 pulse.
- Reset mid-frame: assert i_sys_rst during byte1 of a write -> all o_regs = 0 and FSM idle. A subsequent clean write 0x80 0x3C gives reg0 = 0x3C.
- SCK toggling with SS high, 16 edges -> no register change, no pulses, o_MISO_oe = 0.

Source files
------------

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared types, command-field constants and SPI mode helpers
//                for the spi_slave_regs register-file target.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    // Frame-level protocol states of the target
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_WDATA = 2'd2,
        ST_RDATA = 2'd3
    } state_e;

    // Command byte layout: write flag and start-address field position
    localparam int CMD_WR_BIT   = 7;
    localparam int CMD_ADDR_LSB = 0;

    // Data is sampled on the rising SCK edge when CPOL and CPHA agree,
    // otherwise on the falling edge.
    function automatic logic sample_on_rising(input logic cpol, input logic cpha);
        return (cpol == cpha);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_slave_sync.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave_sync
//  Description : Two-flop synchronisers for SCK/SS/MOSI plus SCK sample/shift
//                edge and SS edge detection in the system clock domain.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_sync
    import spi_pkg::*;
#(
    parameter bit CPOL = 1'b0,
    parameter bit CPHA = 1'b0
) (
    input  logic i_sys_clk,
    input  logic i_sys_rst,
    input  logic i_SCK,
    input  logic i_SS,
    input  logic i_MOSI,
    output logic o_sample_edge,
    output logic o_shift_edge,
    output logic o_ss_fall,
    output logic o_ss_rise,
    output logic o_mosi_s,
    output logic o_ss_s
);

    localparam bit SAMPLE_RISE = sample_on_rising(CPOL, CPHA);

    logic sck_meta_q, sck_sync_q, sck_prev_q;
    logic ss_meta_q,  ss_sync_q,  ss_prev_q;
    logic mosi_meta_q, mosi_sync_q;
    logic w_sck_rise, w_sck_fall;

    // Synchronise the pins and keep one extra sample of SCK/SS for edge detection
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            sck_meta_q  <= CPOL;
            sck_sync_q  <= CPOL;
            sck_prev_q  <= CPOL;
            ss_meta_q   <= 1'b1;
            ss_sync_q   <= 1'b1;
            ss_prev_q   <= 1'b1;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
        end else begin
            sck_meta_q  <= i_SCK;
            sck_sync_q  <= sck_meta_q;
            sck_prev_q  <= sck_sync_q;
            ss_meta_q   <= i_SS;
            ss_sync_q   <= ss_meta_q;
            ss_prev_q   <= ss_sync_q;
            mosi_meta_q <= i_MOSI;
            mosi_sync_q <= mosi_meta_q;
        end
    end

    // Edges are visible combinationally after the second flop, so the
    // consumer registers them on the third system clock after the pin moved.
    assign w_sck_rise    =  sck_sync_q & ~sck_prev_q;
    assign w_sck_fall    = ~sck_sync_q &  sck_prev_q;
    assign o_sample_edge = SAMPLE_RISE ? w_sck_rise : w_sck_fall;
    assign o_shift_edge  = SAMPLE_RISE ? w_sck_fall : w_sck_rise;
    assign o_ss_fall     =  ss_prev_q & ~ss_sync_q;
    assign o_ss_rise     = ~ss_prev_q &  ss_sync_q;
    assign o_mosi_s      = mosi_sync_q;
    assign o_ss_s        = ss_sync_q;

endmodule
`default_nettype wire

// File: rtl/spi_slave_regs.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave_regs
//  Description : SPI target exposing a byte-addressed register file. A command
//                byte selects read/write and start address; following data
//                bytes auto-increment the address with wrap-around.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_regs
    import spi_pkg::*;
#(
    parameter bit CPOL   = 1'b0,
    parameter bit CPHA   = 1'b0,
    parameter int ADDR_W = 3
) (
    input  logic                       i_sys_clk,
    input  logic                       i_sys_rst,
    input  logic                       i_SCK,
    input  logic                       i_SS,
    input  logic                       i_MOSI,
    output logic                       o_MISO,
    output logic                       o_MISO_oe,
    output logic                       o_wr_pulse,
    output logic [ADDR_W-1:0]          o_wr_addr,
    output logic                       o_frame_done,
    output logic [8*(2**ADDR_W)-1:0]   o_regs
);

    localparam int NUM_REGS = 2**ADDR_W;

    logic w_sample_edge, w_shift_edge, w_ss_fall, w_ss_rise, w_mosi_s, w_ss_s;

    state_e              state_q, state_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [7:0]          rx_q, rx_d;
    logic [7:0]          tx_q, tx_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic                skip_q, skip_d;
    logic                wr_pulse_q, wr_pulse_d;
    logic                frame_done_q, frame_done_d;
    logic [7:0]          regs_q [NUM_REGS];
    logic [7:0]          regs_d [NUM_REGS];

    logic [7:0]          w_rx_next;
    logic [ADDR_W-1:0]   w_cmd_addr;
    logic [ADDR_W-1:0]   w_addr_inc;

    spi_slave_sync #(
        .CPOL (CPOL),
        .CPHA (CPHA)
    ) u_sync (
        .i_sys_clk     (i_sys_clk),
        .i_sys_rst     (i_sys_rst),
        .i_SCK         (i_SCK),
        .i_SS          (i_SS),
        .i_MOSI        (i_MOSI),
        .o_sample_edge (w_sample_edge),
        .o_shift_edge  (w_shift_edge),
        .o_ss_fall     (w_ss_fall),
        .o_ss_rise     (w_ss_rise),
        .o_mosi_s      (w_mosi_s),
        .o_ss_s        (w_ss_s)
    );

    assign w_rx_next  = {rx_q[6:0], w_mosi_s};
    assign w_cmd_addr = w_rx_next[CMD_ADDR_LSB +: ADDR_W];
    assign w_addr_inc = addr_q + ADDR_W'(1);

    // Next-state logic for the frame FSM, shifters and register file
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        rx_d         = rx_q;
        tx_d         = tx_q;
        addr_d       = addr_q;
        wr_addr_d    = wr_addr_q;
        skip_d       = skip_q;
        wr_pulse_d   = 1'b0;
        frame_done_d = 1'b0;
        regs_d       = regs_q;

        case (state_q)
            ST_IDLE: begin
                if (w_ss_fall) begin
                    state_d   = ST_CMD;
                    bit_cnt_d = 3'd0;
                    rx_d      = 8'h00;
                    tx_d      = 8'h00;
                    skip_d    = 1'b0;
                end
            end
            default: begin
                if (w_sample_edge) begin
                    rx_d      = w_rx_next;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        case (state_q)
                            ST_CMD: begin
                                addr_d = w_cmd_addr;
                                if (w_rx_next[CMD_WR_BIT]) begin
                                    state_d = ST_WDATA;
                                end else begin
                                    state_d = ST_RDATA;
                                    tx_d    = regs_q[w_cmd_addr];
                                    skip_d  = 1'b1;
                                end
                            end
                            ST_WDATA: begin
                                regs_d[addr_q] = w_rx_next;
                                wr_pulse_d     = 1'b1;
                                wr_addr_d      = addr_q;
                                addr_d         = w_addr_inc;
                            end
                            default: begin
                                tx_d   = regs_q[w_addr_inc];
                                skip_d = 1'b1;
                                addr_d = w_addr_inc;
                            end
                        endcase
                    end
                end
                // The first shift edge after a reload only exposes the MSB,
                // so the freshly loaded byte is not shifted away early.
                if (w_shift_edge) begin
                    if (skip_q) begin
                        skip_d = 1'b0;
                    end else begin
                        tx_d = {tx_q[6:0], 1'b0};
                    end
                end
            end
        endcase

        // Frame end wins over the state update but keeps a write completed
        // on the same cycle; any partial byte is simply dropped.
        if (w_ss_rise) begin
            state_d      = ST_IDLE;
            frame_done_d = 1'b1;
            bit_cnt_d    = 3'd0;
            rx_d         = 8'h00;
            tx_d         = 8'h00;
            skip_d       = 1'b0;
        end
    end

    // State and datapath registers
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 3'd0;
            rx_q         <= 8'h00;
            tx_q         <= 8'h00;
            addr_q       <= '0;
            wr_addr_q    <= '0;
            skip_q       <= 1'b0;
            wr_pulse_q   <= 1'b0;
            frame_done_q <= 1'b0;
            regs_q       <= '{default: 8'h00};
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_q         <= rx_d;
            tx_q         <= tx_d;
            addr_q       <= addr_d;
            wr_addr_q    <= wr_addr_d;
            skip_q       <= skip_d;
            wr_pulse_q   <= wr_pulse_d;
            frame_done_q <= frame_done_d;
            regs_q       <= regs_d;
        end
    end

    generate
        for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_flat
            assign o_regs[8*k +: 8] = regs_q[k];
        end
    endgenerate

    assign o_MISO       = tx_q[7];
    assign o_MISO_oe    = ~w_ss_s;
    assign o_wr_pulse   = wr_pulse_q;
    assign o_wr_addr    = wr_addr_q;
    assign o_frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_regs.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_slave_regs
//  Description : Self-checking bench for spi_slave_regs in SPI modes 0 and 3
//                against a byte-level register-file reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_regs;

    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 8;
    localparam int HALF     = 60;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Shared master pins, steered to the instance of the selected mode
    logic m    = 1'b0;
    logic sck  = 1'b0;
    logic ss   = 1'b1;
    logic mosi = 1'b0;

    logic sck0, ss0, sck1, ss1;
    assign sck0 = m ? 1'b0 : sck;
    assign ss0  = m ? 1'b1 : ss;
    assign sck1 = m ? sck  : 1'b1;
    assign ss1  = m ? ss   : 1'b1;

    logic              miso0, oe0, wp0, fd0, miso1, oe1, wp1, fd1;
    logic [ADDR_W-1:0] wa0, wa1;
    logic [63:0]       regs0, regs1;

    spi_slave_regs #(.CPOL(1'b0), .CPHA(1'b0), .ADDR_W(ADDR_W)) u_dut_m0 (
        .i_sys_clk(clk), .i_sys_rst(rst), .i_SCK(sck0), .i_SS(ss0), .i_MOSI(mosi),
        .o_MISO(miso0), .o_MISO_oe(oe0), .o_wr_pulse(wp0), .o_wr_addr(wa0),
        .o_frame_done(fd0), .o_regs(regs0)
    );

    spi_slave_regs #(.CPOL(1'b1), .CPHA(1'b1), .ADDR_W(ADDR_W)) u_dut_m3 (
        .i_sys_clk(clk), .i_sys_rst(rst), .i_SCK(sck1), .i_SS(ss1), .i_MOSI(mosi),
        .o_MISO(miso1), .o_MISO_oe(oe1), .o_wr_pulse(wp1), .o_wr_addr(wa1),
        .o_frame_done(fd1), .o_regs(regs1)
    );

    logic miso_cur, oe_cur;
    assign miso_cur = m ? miso1 : miso0;
    assign oe_cur   = m ? oe1   : oe0;

    // Reference model: one register array per instance
    logic [7:0] mregs [2][NUM_REGS];
    logic [7:0] dbuf  [4];

    int checks   = 0;
    int failures = 0;
    int pulse_cnt = 0;
    int done_cnt  = 0;
    int paddr_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Observe pulses from both instances away from the active edge
    always @(negedge clk) begin
        if (wp0 || wp1) begin
            pulse_cnt++;
            paddr_q.push_back(int'(m ? wa1 : wa0));
        end
        if (fd0 || fd1) done_cnt++;
    end

    function automatic logic [63:0] model_flat(input int inst);
        logic [63:0] v;
        for (int k = 0; k < NUM_REGS; k++) v[8*k +: 8] = mregs[inst][k];
        return v;
    endfunction

    task automatic clear_obs();
        pulse_cnt = 0;
        done_cnt  = 0;
        paddr_q.delete();
    endtask

    task automatic set_mode(input logic nm);
        m   = nm;
        sck = nm;
        #(HALF*2);
    endtask

    // Clock out the top n bits of tx, MSB first, collecting MISO
    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            if (!m) begin
                mosi = tx[i];
                #HALF;
                rx[i] = miso_cur;
                sck = 1'b1;
                #HALF;
                sck = 1'b0;
            end else begin
                sck  = 1'b0;
                mosi = tx[i];
                #HALF;
                rx[i] = miso_cur;
                sck = 1'b1;
                #HALF;
            end
        end
    endtask

    task automatic frame_begin();
        ss = 1'b0;
        #(HALF*2);
    endtask

    task automatic frame_end();
        #HALF;
        ss = 1'b1;
        #(HALF*2);
    endtask

    // Complete frame: command plus nd data bytes (write data from dbuf)
    task automatic run_frame(input logic [7:0] cmd, input int nd);
        logic [7:0] rx;
        int         a;
        int         exp_addr[$];
        a = int'(cmd[ADDR_W-1:0]);
        clear_obs();
        check("oe_before", {63'd0, oe_cur}, 64'd0);
        frame_begin();
        check("oe_during", {63'd0, oe_cur}, 64'd1);
        spi_bits(cmd, 8, rx);
        check("cmd_miso", {56'd0, rx}, 64'd0);
        for (int j = 0; j < nd; j++) begin
            if (cmd[7]) begin
                spi_bits(dbuf[j], 8, rx);
                mregs[m][(a + j) % NUM_REGS] = dbuf[j];
                exp_addr.push_back((a + j) % NUM_REGS);
            end else begin
                spi_bits(8'($urandom), 8, rx);
                check("rd_byte", {56'd0, rx}, {56'd0, mregs[m][(a + j) % NUM_REGS]});
            end
        end
        frame_end();
        check("oe_after", {63'd0, oe_cur}, 64'd0);
        check("pulse_cnt", 64'(pulse_cnt), 64'(exp_addr.size()));
        for (int j = 0; j < exp_addr.size() && j < paddr_q.size(); j++)
            check("wr_addr", 64'(paddr_q[j]), 64'(exp_addr[j]));
        check("frame_done", 64'(done_cnt), 64'd1);
        check("regs", m ? regs1 : regs0, model_flat(int'(m)));
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] rx;
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < NUM_REGS; k++) mregs[i][k] = 8'h00;

        // Reset state
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_regs", regs0, 64'd0);
        check("rst_miso", {63'd0, miso0}, 64'd0);
        check("rst_oe", {63'd0, oe0}, 64'd0);
        check("rst_wp", {63'd0, wp0}, 64'd0);
        check("rst_wa", {61'd0, wa0}, 64'd0);
        check("rst_fd", {63'd0, fd0}, 64'd0);
        #(HALF*2);

        // Mode 0 write of two bytes
        dbuf[0] = 8'h11; dbuf[1] = 8'h22;
        run_frame(8'h82, 2);
        check("reg2", {56'd0, regs0[16 +: 8]}, 64'h11);
        check("reg3", {56'd0, regs0[24 +: 8]}, 64'h22);

        // Address wrap on write then read back across the wrap
        dbuf[0] = 8'hAA; dbuf[1] = 8'hBB;
        run_frame(8'h87, 2);
        run_frame(8'h07, 2);
        check("reg7", {56'd0, regs0[56 +: 8]}, 64'hAA);
        check("reg0", {56'd0, regs0[0 +: 8]}, 64'hBB);

        // Mode 3 write then read
        set_mode(1'b1);
        dbuf[0] = 8'h5C;
        run_frame(8'h82, 1);
        run_frame(8'h02, 1);

        // Abort mid-byte in mode 0
        set_mode(1'b0);
        clear_obs();
        frame_begin();
        spi_bits(8'h81, 8, rx);
        spi_bits(8'hFF, 5, rx);
        frame_end();
        check("abort_pulse", 64'(pulse_cnt), 64'd0);
        check("abort_done", 64'(done_cnt), 64'd1);
        check("abort_reg1", {56'd0, regs0[8 +: 8]}, 64'h00);

        // Reset in the middle of a write data byte
        frame_begin();
        spi_bits(8'h81, 8, rx);
        spi_bits(8'hF0, 4, rx);
        @(negedge clk);
        rst = 1'b1;
        ss  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < NUM_REGS; k++) mregs[i][k] = 8'h00;
        @(negedge clk);
        check("midrst_regs0", regs0, 64'd0);
        check("midrst_regs1", regs1, 64'd0);
        check("midrst_oe", {63'd0, oe0}, 64'd0);
        #(HALF*2);
        dbuf[0] = 8'h3C;
        run_frame(8'h80, 1);
        check("post_rst_reg0", {56'd0, regs0[0 +: 8]}, 64'h3C);

        // SCK activity with SS high must be ignored
        clear_obs();
        for (int i = 0; i < 16; i++) begin
            mosi = 1'($urandom);
            sck  = ~sck;
            #HALF;
        end
        #(HALF*2);
        check("ssh_pulse", 64'(pulse_cnt), 64'd0);
        check("ssh_done", 64'(done_cnt), 64'd0);
        check("ssh_oe", {63'd0, oe_cur}, 64'd0);
        check("ssh_regs", regs0, model_flat(0));

        // Randomized frames in both modes
        for (int t = 0; t < 24; t++) begin
            logic [7:0] cmd;
            int         nd;
            if ($urandom_range(0, 3) == 0) set_mode(~m);
            cmd = 8'($urandom);
            nd  = $urandom_range(1, 4);
            for (int j = 0; j < 4; j++) dbuf[j] = 8'($urandom);
            run_frame(cmd, nd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
